// File: rtl/bvh_primitive_serializer_if.sv
// Handshake bundle for the BVH primitive serializer: record input channel and word output stream.
// master = the environment (record source and stream sink); slave = the serializer itself.
interface bvh_primitive_serializer_if #(
  parameter int FIXED_WIDTH = 32,
  parameter int COLOR_WIDTH = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [FIXED_WIDTH-1:0]   in_min_x;
  logic [FIXED_WIDTH-1:0]   in_min_y;
  logic [FIXED_WIDTH-1:0]   in_min_z;
  logic [FIXED_WIDTH-1:0]   in_max_x;
  logic [FIXED_WIDTH-1:0]   in_max_y;
  logic [FIXED_WIDTH-1:0]   in_max_z;
  logic [3*COLOR_WIDTH-1:0] in_color;
  logic                     out_valid;
  logic                     out_ready;
  logic [FIXED_WIDTH-1:0]   out_data;
  logic [2:0]               out_index;
  logic                     out_last;

  modport master (
    output in_valid, in_min_x, in_min_y, in_min_z, in_max_x, in_max_y, in_max_z, in_color,
    output out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );

  modport slave (
    input  in_valid, in_min_x, in_min_y, in_min_z, in_max_x, in_max_y, in_max_z, in_color,
    input  out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/bvh_primitive_serializer.sv
// Serializes one AABB primitive record into the primitive hex-dump word order.
// Optional macro SERIALIZER_CHECKSUM_EN appends an XOR checksum word at index 7.
module bvh_primitive_serializer #(
  parameter int FIXED_WIDTH = 32,
  parameter int COLOR_WIDTH = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  bvh_primitive_serializer_if.slave bus,
  output logic [COUNT_WIDTH-1:0]    prim_count
);

`ifdef SERIALIZER_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd7;
`else
  localparam logic [2:0] LAST_IDX = 3'd6;
`endif

  if (3 * COLOR_WIDTH > FIXED_WIDTH) begin : g_width_check
    $error("bvh_primitive_serializer: 3*COLOR_WIDTH must not exceed FIXED_WIDTH");
  end

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                   state_q, state_d;
  logic [2:0]               idx_q, idx_d;
  logic [FIXED_WIDTH-1:0]   coord_q [6];
  logic [3*COLOR_WIDTH-1:0] color_q;
  logic                     capture;
  logic                     rec_done;
  logic [FIXED_WIDTH-1:0]   word;

`ifdef SERIALIZER_CHECKSUM_EN
  logic [FIXED_WIDTH-1:0] checksum;

  // Derived from the captured record, so it always equals the XOR of words 0..6 as emitted.
  always_comb begin
    checksum = FIXED_WIDTH'(color_q);
    for (int i = 0; i < 6; i++) begin
      checksum = checksum ^ coord_q[i];
    end
  end
`endif

  always_comb begin
    word = '0;
    case (idx_q)
      3'd0:    word = coord_q[0];
      3'd1:    word = coord_q[1];
      3'd2:    word = coord_q[2];
      3'd3:    word = coord_q[3];
      3'd4:    word = coord_q[4];
      3'd5:    word = coord_q[5];
      3'd6:    word = FIXED_WIDTH'(color_q);
`ifdef SERIALIZER_CHECKSUM_EN
      3'd7:    word = checksum;
`endif
      default: word = '0;
    endcase
  end

  // NOTE: every output of this combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    capture       = 1'b0;
    rec_done      = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_index = '0;
    bus.out_last  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = reset_n;
        if (bus.in_valid && reset_n) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        bus.out_valid = 1'b1;
        bus.out_data  = word;
        bus.out_index = idx_q;
        bus.out_last  = (idx_q == LAST_IDX);
        // A new record may only enter on the same edge that retires the last word.
        bus.in_ready  = (idx_q == LAST_IDX) && bus.out_ready;
        if (bus.out_ready) begin
          if (idx_q == LAST_IDX) begin
            rec_done = 1'b1;
            idx_d    = '0;
            if (bus.in_valid) begin
              capture = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the captured record is reset as well, so a reset mid-record leaves no stale words behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      color_q    <= '0;
      prim_count <= '0;
      for (int i = 0; i < 6; i++) begin
        coord_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments here, so every register updates from pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      if (capture) begin
        coord_q[0] <= bus.in_min_x;
        coord_q[1] <= bus.in_min_y;
        coord_q[2] <= bus.in_min_z;
        coord_q[3] <= bus.in_max_x;
        coord_q[4] <= bus.in_max_y;
        coord_q[5] <= bus.in_max_z;
        color_q    <= bus.in_color;
      end
      if (rec_done) begin
        prim_count <= prim_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/bvh_primitive_serializer.md
Name: bvh_primitive_serializer

Overview:
- Accepts one BVH AABB primitive per handshake: min/max corners as raw fixed-point words, plus a packed RGB colour.
- Streams the primitive out as a fixed sequence of FIXED_WIDTH-bit words on a valid/ready interface.
- The word order is the same one the primitive hex dump files use, so the stream can be written straight to memory or a host link and later reloaded as primitive records.
- Sits between the BVH builder/primitive store and the memory-write or host-dump path.

Parameters:
- FIXED_WIDTH, 32, width of one fixed-point coordinate and of OUT_DATA.
- COLOR_WIDTH, 8, bits per colour channel; 3*COLOR_WIDTH must be <= FIXED_WIDTH (elaboration-time check, $error on violation).
- COUNT_WIDTH, 16, width of PRIM_COUNT.

Ports:
- CLK  in  1  single clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  primitive record valid.
- IN_READY  out  1  block can accept a record.
- IN_MIN_X / IN_MIN_Y / IN_MIN_Z  in  FIXED_WIDTH each  AABB min corner, raw bits.
- IN_MAX_X / IN_MAX_Y / IN_MAX_Z  in  FIXED_WIDTH each  AABB max corner, raw bits.
- IN_COLOR  in  3*COLOR_WIDTH  {ch2, ch1, ch0}; ch0 in the LSBs.
- OUT_VALID  out  1  output word valid.
- OUT_READY  in  1  downstream accepts word.
- OUT_DATA  out  FIXED_WIDTH  current word.
- OUT_INDEX  out  3  index of current word within the record.
- OUT_LAST  out  1  current word is the record's final word.
- PRIM_COUNT  out  COUNT_WIDTH  number of records fully emitted.

Behaviour:
- Reset (RESET_N low, async):
  - State to IDLE, captured record cleared.
  - OUT_VALID=0, OUT_DATA=0, OUT_INDEX=0, OUT_LAST=0, PRIM_COUNT=0.
  - IN_READY=0 while RESET_N is low.
  - A reset mid-record discards the record; no partial words are emitted after release.
- FSM states: IDLE, SEND.
- IDLE:
  - IN_READY=1, OUT_VALID=0, OUT_DATA=0.
  - IN_VALID&&IN_READY captures all inputs into internal registers, sets idx=0 and moves to SEND.
  - First word is valid the cycle after acceptance (latency 1).
- SEND:
  - OUT_VALID=1; OUT_INDEX=idx; OUT_DATA=word[idx], selected from the captured registers.
  - Word order: 0 MIN_X, 1 MIN_Y, 2 MIN_Z, 3 MAX_X, 4 MAX_Y, 5 MAX_Z, 6 COLOR.
  - COLOR word is zero-extended {0, ch2, ch1, ch0}.
  - OUT_DATA, OUT_INDEX and OUT_LAST hold stable while OUT_VALID&&!OUT_READY.
  - On OUT_VALID&&OUT_READY: idx increments. OUT_LAST=1 only when idx==LAST (6 without the optional feature).
- End of record:
  - A handshake on the last word increments PRIM_COUNT (wraps modulo 2^COUNT_WIDTH, no saturation).
- Back-to-back:
  - In SEND, IN_READY = (idx==LAST) && OUT_READY (combinational from OUT_READY).
  - If IN_VALID is also high that cycle, the new record is captured, idx resets to 0 and the state stays SEND. Word 0 of the new record follows the old last word with no bubble.
  - Otherwise the state returns to IDLE.
  - Steady throughput is one record per LAST+1 cycles.
- Record inputs are sampled only on the accepting edge; changes while not accepted are ignored.
- Coordinates pass through bit-exact; no sign handling or arithmetic.

Optional Feature:
- Macro: SERIALIZER_CHECKSUM_EN.
- Defined:
  - An 8th word (index 7) is appended: XOR of words 0..6 as emitted.
  - LAST=7; OUT_LAST is asserted on word 7; PRIM_COUNT increments on the word-7 handshake.
  - The checksum register is cleared on capture and accumulated on each word handshake, or computed from the captured registers; either implementation must give an identical value.
- Undefined:
  - 7 words per record; LAST=6; no checksum logic present.

Test Plan:
- Reset, then one record MIN=(0x00010000, 0xFFFF0000, 0x00008000), MAX=(0x00020000, 0x00000000, 0x00018000), COLOR=0x3366CC, OUT_READY=1 -> words 0x00010000, 0xFFFF0000, 0x00008000, 0x00020000, 0x00000000, 0x00018000, 0x003366CC on consecutive cycles starting 1 cycle after accept. OUT_LAST only on index 6; PRIM_COUNT=1. With SERIALIZER_CHECKSUM_EN, an 8th word equal to the XOR of these 7 words follows.
- Same record, OUT_READY toggling 1,0,0,1 repeating -> OUT_DATA/OUT_INDEX stable during stalls; all 7 words in order; no duplicates or drops.
- Two records presented with IN_VALID held high and OUT_READY=1 -> second record's word 0 in the cycle right after the first's last word; PRIM_COUNT=2 after 14 words (16 with checksum).
- Assert RESET_N low while OUT_INDEX=3 -> OUT_VALID=0 and PRIM_COUNT=0 immediately (async). After release, IN_READY=1 and no leftover words appear.
- Force PRIM_COUNT to 0xFFFF via 65535 records (or a preload hook in the bench), then send one more -> PRIM_COUNT wraps to 0x0000.
- IN_VALID high while in SEND at idx<LAST -> IN_READY=0 and the record is not captured; it is accepted only on the last-word handshake.
